// File: rtl/logging_memwindow_pf.sv
// Sbus window onto a logging blockram: four 16-bit registers, one-word
// read prefetch, DATA write path, programmable stride, wrap/saturate modes.
module logging_memwindow_pf #(
    parameter int DW    = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            sbus_wb_cyc_i,
    input  logic            sbus_wb_stb_i,
    input  logic            sbus_wb_we_i,
    input  logic [15:0]     sbus_wb_adr_i,
    input  logic [DW/8-1:0] sbus_wb_sel_i,
    input  logic [DW-1:0]   sbus_wb_dat_i,
    output logic [DW-1:0]   sbus_wb_dat_o,
    output logic            sbus_wb_ack_o,
    output logic            lbram_wb_cyc_o,
    output logic            lbram_wb_stb_o,
    output logic            lbram_wb_we_o,
    output logic [AW-1:0]   lbram_wb_adr_o,
    output logic [DW/8-1:0] lbram_wb_sel_o,
    output logic [DW-1:0]   lbram_wb_dat_o,
    input  logic [DW-1:0]   lbram_wb_dat_i,
    input  logic            lbram_wb_ack_i
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREFETCH = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;

    localparam logic [1:0] R_ADDR   = 2'd0;
    localparam logic [1:0] R_DATA   = 2'd1;
    localparam logic [1:0] R_CTRL   = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] adr;
    logic [AW-1:0] bram_adr;
    logic          autoinc, wrap;
    logic [3:0]    stride_m1;
    logic          ovf;
    logic          pf_valid;
    logic [DW-1:0] pf_data;
    logic          reload;

    logic [1:0]    rsel;
    logic          req, ready, take;
    logic          rd_ok, wr_done;
    logic          addr_wr, ctrl_wr, stat_wr, data_take;
    logic          pf_done;
    logic [AW-1:0] wa;
    logic          wa_big;
    logic [AW:0]   stride_w, nxt;
    logic [AW-1:0] adv_adr;
    logic          adv_ovf;
    logic [DW-1:0] ctrl_rd, stat_rd, rd_mux;
    logic          unused;

    assign unused    = ^{sbus_wb_adr_i[15:3], sbus_wb_adr_i[0]};
    assign rsel      = sbus_wb_adr_i[2:1];
    assign req       = sbus_wb_cyc_i & sbus_wb_stb_i & ~sbus_wb_ack_o;
    assign rd_ok     = (state == S_IDLE) & pf_valid & ~reload;
    assign wr_done   = (state == S_WRITE) & lbram_wb_ack_i;
    assign pf_done   = (state == S_PREFETCH) & lbram_wb_ack_i;
    assign take      = req & ready;
    assign addr_wr   = take & sbus_wb_we_i & (rsel == R_ADDR);
    assign ctrl_wr   = take & sbus_wb_we_i & (rsel == R_CTRL);
    assign stat_wr   = take & sbus_wb_we_i & (rsel == R_STATUS);
    assign data_take = take & (rsel == R_DATA);
    assign wa        = sbus_wb_dat_i[AW-1:0];
    assign wa_big    = {1'b0, wa} >= DEPTH_W;

    // Register-access readiness: only DATA ever has to wait
    always_comb begin
        ready = 1'b1;
        if (rsel == R_DATA)
            ready = sbus_wb_we_i ? wr_done : rd_ok;
    end

    // Next window address after a DATA access, with wrap or saturation
    always_comb begin
        stride_w = (AW+1)'(stride_m1) + (AW+1)'(1);
        nxt      = {1'b0, adr} + stride_w;
        adv_adr  = adr;
        adv_ovf  = 1'b0;
        if (autoinc) begin
            if (nxt >= DEPTH_W) begin
                if (wrap) begin
                    adv_adr = AW'(nxt - DEPTH_W);
                end else begin
                    adv_adr = LAST;
                    adv_ovf = 1'b1;
                end
            end else begin
                adv_adr = nxt[AW-1:0];
            end
        end
    end

    // Read-back values for the register map
    always_comb begin
        ctrl_rd      = '0;
        ctrl_rd[0]   = autoinc;
        ctrl_rd[1]   = wrap;
        ctrl_rd[7:4] = stride_m1;
        stat_rd      = '0;
        stat_rd[0]   = (state != S_IDLE);
        stat_rd[1]   = pf_valid;
        stat_rd[2]   = ovf;
        unique case (rsel)
            R_ADDR:  rd_mux = DW'(adr);
            R_DATA:  rd_mux = pf_data;
            R_CTRL:  rd_mux = ctrl_rd;
            default: rd_mux = stat_rd;
        endcase
    end

    // Bram cycle sequencing; an ADDR write in IDLE defers the prefetch a cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req & sbus_wb_we_i & (rsel == R_DATA))
                    state_nxt = S_WRITE;
                else if (~pf_valid & ~addr_wr)
                    state_nxt = S_PREFETCH;
            end
            S_PREFETCH: if (lbram_wb_ack_i) state_nxt = S_IDLE;
            S_WRITE:    if (lbram_wb_ack_i) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM state and the bram address latched for the whole bram cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= S_IDLE;
            bram_adr <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && (state_nxt != S_IDLE))
                bram_adr <= adr;
        end
    end

    // Window address, control fields and sticky overflow
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr       <= '0;
            autoinc   <= 1'b1;
            wrap      <= 1'b0;
            stride_m1 <= '0;
            ovf       <= 1'b0;
        end else begin
            if (addr_wr)
                adr <= wa_big ? LAST : wa;
            else if (data_take)
                adr <= adv_adr;
            if (ctrl_wr) begin
                autoinc   <= sbus_wb_dat_i[0];
                wrap      <= sbus_wb_dat_i[1];
                stride_m1 <= sbus_wb_dat_i[7:4];
            end
            if ((addr_wr & wa_big) | (data_take & adv_ovf))
                ovf <= 1'b1;
            else if (stat_wr & sbus_wb_dat_i[2])
                ovf <= 1'b0;
        end
    end

    // Prefetch buffer; reload discards a prefetch overtaken by an ADDR write
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pf_valid <= 1'b0;
            pf_data  <= '0;
            reload   <= 1'b0;
        end else begin
            if (addr_wr | data_take) begin
                pf_valid <= 1'b0;
            end else if (pf_done & ~reload) begin
                pf_valid <= 1'b1;
                pf_data  <= lbram_wb_dat_i;
            end
            if (pf_done)
                reload <= 1'b0;
            else if (addr_wr & (state == S_PREFETCH))
                reload <= 1'b1;
        end
    end

    // Sbus ack pulse and registered read data
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sbus_wb_ack_o <= 1'b0;
            sbus_wb_dat_o <= '0;
        end else begin
            sbus_wb_ack_o <= take;
            if (take & ~sbus_wb_we_i)
                sbus_wb_dat_o <= rd_mux;
        end
    end

    // Bram master outputs follow the state so reset drops them at once
    always_comb begin
        lbram_wb_cyc_o = (state != S_IDLE);
        lbram_wb_stb_o = (state != S_IDLE);
        lbram_wb_we_o  = (state == S_WRITE);
        lbram_wb_adr_o = bram_adr;
        lbram_wb_sel_o = '0;
        lbram_wb_dat_o = '0;
        if (state == S_WRITE) begin
            lbram_wb_sel_o = sbus_wb_sel_i;
            lbram_wb_dat_o = sbus_wb_dat_i;
        end else if (state == S_PREFETCH) begin
            lbram_wb_sel_o = '1;
        end
    end

endmodule

// File: tb/tb_logging_memwindow_pf.sv
// Randomised scoreboard bench for logging_memwindow_pf against a
// register-level reference model and a latency-configurable bram.
module tb_logging_memwindow_pf;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_cyc = 0, s_stb = 0, s_we = 0;
    logic [15:0] s_adr = '0;
    logic [1:0]  s_sel = '0;
    logic [15:0] s_dat_w = '0;
    logic [15:0] s_dat_r;
    logic        s_ack;
    logic        l_cyc, l_stb, l_we;
    logic [11:0] l_adr;
    logic [1:0]  l_sel;
    logic [15:0] l_dat_w;
    logic [15:0] l_dat_r = '0;
    logic        l_ack = 1'b0;

    logging_memwindow_pf #(.DW(16), .AW(12), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .sbus_wb_cyc_i(s_cyc), .sbus_wb_stb_i(s_stb),
        .sbus_wb_we_i(s_we), .sbus_wb_adr_i(s_adr),
        .sbus_wb_sel_i(s_sel), .sbus_wb_dat_i(s_dat_w),
        .sbus_wb_dat_o(s_dat_r), .sbus_wb_ack_o(s_ack),
        .lbram_wb_cyc_o(l_cyc), .lbram_wb_stb_o(l_stb),
        .lbram_wb_we_o(l_we), .lbram_wb_adr_o(l_adr),
        .lbram_wb_sel_o(l_sel), .lbram_wb_dat_o(l_dat_w),
        .lbram_wb_dat_i(l_dat_r), .lbram_wb_ack_i(l_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [1:0]  r;
        logic [15:0] d;
        logic [15:0] m;
    } exp_t;

    typedef struct {
        bit we;
        int adr;
    } txn_t;

    exp_t        exp_q[$];
    txn_t        blog[$];
    logic [15:0] bram[DEPTH];
    logic [15:0] ref_mem[DEPTH];
    int          lat = 2;
    int          bcnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          last_lat = 0;
    bit          prev_ack = 0;

    int          m_adr, m_stride, m_ovf;
    bit          m_ai, m_wrap;

    function automatic string rname(input logic [1:0] r);
        case (r)
            2'd0: return "ADDR";
            2'd1: return "DATA";
            2'd2: return "CTRL";
            default: return "STATUS";
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_adr = 0; m_ai = 1; m_wrap = 0; m_stride = 1; m_ovf = 0;
    endtask

    task automatic model_advance();
        int n;
        if (!m_ai) return;
        n = m_adr + m_stride;
        if (n >= DEPTH) begin
            if (m_wrap) n = n - DEPTH;
            else begin n = DEPTH - 1; m_ovf = 1; end
        end
        m_adr = n;
    endtask

    // Bram slave: ack after 'lat' cycles of cyc/stb, driven on negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            l_ack = 0; bcnt = 0;
        end else if (l_ack) begin
            l_ack = 0; bcnt = 0;
        end else if (l_cyc && l_stb) begin
            if (bcnt == 0) blog.push_back('{l_we, int'(l_adr)});
            bcnt++;
            if (bcnt >= lat) begin
                if (l_we) begin
                    if (l_sel[0]) bram[l_adr][7:0] = l_dat_w[7:0];
                    if (l_sel[1]) bram[l_adr][15:8] = l_dat_w[15:8];
                end else begin
                    l_dat_r = bram[l_adr];
                end
                l_ack = 1;
            end
        end else begin
            bcnt = 0;
        end
    end

    // Monitor: every sbus ack pops one expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ack = 0;
        end else begin
            if (s_ack) begin
                if (prev_ack) check("ack_back_to_back", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd)
                        check({"rd_", rname(e.r)}, int'(s_dat_r & e.m),
                              int'(e.d & e.m));
                end
            end
            prev_ack = s_ack;
        end
    end

    task automatic sbus(input bit we, input logic [1:0] r,
                        input logic [15:0] d, input logic [1:0] sel);
        exp_t e;
        int n;
        int wa;
        e.rd = !we; e.r = r; e.d = '0; e.m = 16'hFFFF;
        case (r)
            2'd0: begin
                if (we) begin
                    wa = int'(d & 16'h0FFF);
                    if (wa >= DEPTH) begin m_adr = DEPTH - 1; m_ovf = 1; end
                    else m_adr = wa;
                end else e.d = 16'(m_adr);
            end
            2'd1: begin
                if (we) begin
                    if (sel[0]) ref_mem[m_adr][7:0] = d[7:0];
                    if (sel[1]) ref_mem[m_adr][15:8] = d[15:8];
                end else e.d = ref_mem[m_adr];
                model_advance();
            end
            2'd2: begin
                if (we) begin
                    m_ai = d[0]; m_wrap = d[1]; m_stride = int'(d[7:4]) + 1;
                end else begin
                    e.d = 16'((m_stride - 1) * 16 + (m_wrap ? 2 : 0)
                              + (m_ai ? 1 : 0));
                end
            end
            default: begin
                if (we) begin
                    if (d[2]) m_ovf = 0;
                end else begin
                    e.d = 16'(m_ovf * 4);
                    e.m = 16'hFFFC;
                end
            end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        s_cyc = 1; s_stb = 1; s_we = we;
        s_adr = {13'd0, r, 1'b0}; s_dat_w = d; s_sel = sel;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!s_ack && n < 300);
        last_lat = n;
        check({"ack_", rname(r)}, int'(s_ack), 1);
        @(negedge clk);
        s_cyc = 0; s_stb = 0; s_we = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        bit found;
        int op;
        logic [15:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i] = 16'($urandom);
            ref_mem[i] = bram[i];
        end
        bram[12'h201] = 16'h1111; ref_mem[12'h201] = 16'h1111;
        bram[12'h345] = 16'h2222; ref_mem[12'h345] = 16'h2222;
        model_reset();

        // 1: reset state and first prefetch
        repeat (3) @(posedge clk);
        #1;
        check("rst_lb_cyc", int'(l_cyc), 0);
        check("rst_s_ack", int'(s_ack), 0);
        check("rst_s_dat", int'(s_dat_r), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(posedge clk);
        check("first_bram_txn_count", int'(blog.size() >= 1), 1);
        if (blog.size() >= 1) begin
            check("first_bram_we", int'(blog[0].we), 0);
            check("first_bram_adr", blog[0].adr, 0);
        end
        sbus(0, 2'd1, 16'h0, 2'b11);
        check("pf_hit_latency", last_lat, 1);
        sbus(0, 2'd0, 16'h0, 2'b11);
        sbus(0, 2'd2, 16'h0, 2'b11);

        // 2: stride 4
        sbus(1, 2'd0, 16'h0100, 2'b11);
        sbus(1, 2'd2, 16'h0031, 2'b11);
        for (int i = 0; i < 3; i++) sbus(0, 2'd1, 16'h0, 2'b11);
        sbus(0, 2'd0, 16'h0, 2'b11);

        // 3: write at the top with saturation and OVF clear
        sbus(1, 2'd0, 16'h0FFF, 2'b11);
        sbus(1, 2'd1, 16'hBEEF, 2'b11);
        check("bram_fff", int'(bram[12'hFFF]), 16'hBEEF);
        check("bram_write_adr", blog[blog.size()-1].adr, 12'hFFF);
        check("bram_write_we", int'(blog[blog.size()-1].we), 1);
        sbus(0, 2'd3, 16'h0, 2'b11);
        sbus(0, 2'd0, 16'h0, 2'b11);
        sbus(1, 2'd3, 16'h0004, 2'b11);
        sbus(0, 2'd3, 16'h0, 2'b11);

        // 4: wrap
        sbus(1, 2'd2, 16'h0003, 2'b11);
        sbus(1, 2'd0, 16'h0FFE, 2'b11);
        sbus(0, 2'd1, 16'h0, 2'b11);
        sbus(0, 2'd1, 16'h0, 2'b11);
        sbus(0, 2'd0, 16'h0, 2'b11);
        sbus(0, 2'd3, 16'h0, 2'b11);

        // 5: ADDR write over a stalled prefetch
        sbus(1, 2'd2, 16'h0001, 2'b11);
        lat = 1;
        sbus(1, 2'd0, 16'h0200, 2'b11);
        repeat (4) @(posedge clk);
        lat = 6;
        sbus(0, 2'd1, 16'h0, 2'b11);
        idx = blog.size();
        sbus(1, 2'd0, 16'h0345, 2'b11);
        check("stall_cyc", int'(l_cyc), 1);
        check("stall_adr", int'(l_adr), 12'h201);
        sbus(0, 2'd1, 16'h0, 2'b11);
        found = 0;
        for (int i = idx; i < blog.size(); i++)
            if (!blog[i].we && blog[i].adr == 12'h345) found = 1;
        check("reload_read_new_adr", int'(found), 1);

        // 6: reset during a pending bram write
        lat = 8;
        @(negedge clk);
        s_cyc = 1; s_stb = 1; s_we = 1; s_adr = 16'h0002;
        s_dat_w = 16'h5A5A; s_sel = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (l_we) break;
        end
        check("write_pending", int'(l_we), 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_cyc", int'(l_cyc), 0);
        check("rst_async_stb", int'(l_stb), 0);
        s_cyc = 0; s_stb = 0; s_we = 0;
        repeat (2) @(negedge clk);
        model_reset();
        lat = 2;
        idx = blog.size();
        rst_n = 1;
        repeat (6) @(posedge clk);
        check("post_rst_txn", int'(blog.size() > idx), 1);
        if (blog.size() > idx) begin
            check("post_rst_pf_we", int'(blog[idx].we), 0);
            check("post_rst_pf_adr", blog[idx].adr, 0);
        end
        sbus(0, 2'd0, 16'h0, 2'b11);
        sbus(0, 2'd2, 16'h0, 2'b11);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            lat = $urandom_range(1, 4);
            op = $urandom_range(0, 9);
            v = 16'($urandom);
            case (op)
                0: sbus(1, 2'd0, ($urandom_range(0, 3) == 0) ?
                        (16'h0FE0 | (v & 16'h001F)) : v, 2'b11);
                1: sbus(1, 2'd2, v & 16'h00F3, 2'b11);
                2, 3: sbus(1, 2'd1, v, 2'($urandom_range(0, 3)));
                4, 5, 6: sbus(0, 2'd1, 16'h0, 2'b11);
                7: sbus(0, 2'd0, 16'h0, 2'b11);
                8: sbus(0, 2'($urandom_range(2, 3)), 16'h0, 2'b11);
                default: sbus(1, 2'd3, v, 2'b11);
            endcase
        end
        sbus(0, 2'd3, 16'h0, 2'b11);
        sbus(0, 2'd0, 16'h0, 2'b11);

        repeat (3) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logging_memwindow_pf.md
Name: logging_memwindow_pf

Overview:
- Parametrised, read/write sbus window onto a logging blockram of up to 2^AW words; successor to the fixed 2048x16 read-only window.
- Wishbone slave on the sbus side exposes four 16-bit registers. Wishbone master on the blockram side has one outstanding cycle.
- Adds a one-word read prefetch buffer, a DATA write path, a programmable increment stride, wrap/saturate address modes and a sticky overflow flag.

Parameters:
- DW, 16, data width on both buses (multiple of 8).
- AW, 12, blockram address width.
- DEPTH, 4096, number of valid words (2 <= DEPTH <= 2^AW); the address range is 0..DEPTH-1.

Ports:
- wb_clk_i  in  1  master clock, all logic on rising edge
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- sbus_wb_cyc_i  in  1  sbus cycle
- sbus_wb_stb_i  in  1  sbus strobe
- sbus_wb_we_i  in  1  sbus write enable
- sbus_wb_adr_i  in  16  byte address; only bits [2:1] are decoded
- sbus_wb_sel_i  in  DW/8  byte selects, passed through on DATA writes
- sbus_wb_dat_i  in  DW  write data
- sbus_wb_dat_o  out  DW  read data
- sbus_wb_ack_o  out  1  registered ack
- lbram_wb_cyc_o  out  1  bram cycle
- lbram_wb_stb_o  out  1  bram strobe
- lbram_wb_we_o  out  1  bram write enable
- lbram_wb_adr_o  out  AW  bram word address
- lbram_wb_sel_o  out  DW/8  bram byte selects
- lbram_wb_dat_o  out  DW  bram write data
- lbram_wb_dat_i  in  DW  bram read data
- lbram_wb_ack_i  in  1  bram ack

Behaviour:

Register map (byte offsets):
- 0x0 ADDR (RW): read returns adr zero-extended.
- 0x2 DATA (RW).
- 0x4 CTRL (RW): bit0 AUTOINC, bit1 WRAP, bits[7:4] STRIDE-1, so stride range is 1..16.
- 0x6 STATUS: bit0 BUSY (R), bit1 PF_VALID (R), bit2 OVF (sticky, write-1-to-clear).
- Unused register bits read 0.

Reset values:
- adr=0, AUTOINC=1, WRAP=0, STRIDE-1=0, OVF=0, pf_valid=0.
- All outputs 0.
- After reset release, the FSM immediately enters PREFETCH for address 0.

sbus ack:
- sbus_wb_ack_o <= cyc & stb & ready & !ack. It is a one-cycle pulse and is never asserted on two consecutive cycles.
- ADDR, CTRL and STATUS accesses are always ready, so they ack on the cycle after the strobe.
- Register writes take effect on the ack edge.

FSM states: IDLE, PREFETCH, WRITE.
- IDLE -> PREFETCH when pf_valid=0 or a reload is pending.
- IDLE -> WRITE on a DATA write request.
- PREFETCH: drives cyc/stb=1, we=0, adr=adr. On lbram ack: if no reload is pending, capture pf_data and set pf_valid=1; go to IDLE.
- WRITE: drives cyc/stb/we=1 with adr, sbus_wb_dat_i and sbus_wb_sel_i. On lbram ack: sbus ack on the next cycle, advance, pf_valid=0; go to IDLE.
- cyc/stb stay asserted until lbram ack. There is never more than one bram cycle in flight.

DATA read:
- Ready when pf_valid=1 and state is IDLE. Ack returns pf_data.
- On the ack edge: clear pf_valid and advance.
- Minimum latency is 1 cycle. On a prefetch miss, ack follows the prefetch completion by 1 cycle.

DATA write:
- Ready when state is IDLE, after which it is serviced via WRITE.
- A write arriving during PREFETCH waits for that prefetch to complete.

Advance:
- AUTOINC=0: adr unchanged.
- AUTOINC=1: nxt = adr + stride, computed at width AW+1.
- If nxt >= DEPTH: with WRAP=1, adr = nxt - DEPTH; with WRAP=0, adr = DEPTH-1 and OVF is set.

ADDR write:
- Bits above AW are ignored.
- A value >= DEPTH loads DEPTH-1 and sets OVF.
- pf_valid is cleared.
- If a PREFETCH is in flight, that cycle completes, its data is discarded, and a new prefetch is issued (reload pending).

CTRL write: does not invalidate the prefetch buffer.

Simultaneous events: when an OVF set and a W1C clear land in the same cycle, set wins.

Reset mid-operation: all state returns to reset values immediately, and bram cyc/stb drop asynchronously.

Test Plan:
1. Reset release, bram latency 2 -> PREFETCH of adr 0. First DATA read returns mem[0] 1 cycle after strobe; ADDR read then returns 0x0001.
2. Write ADDR=0x0100, CTRL=0x0031 (stride 4, autoinc) -> three DATA reads return mem[0x100], mem[0x104], mem[0x108]; ADDR reads 0x010C.
3. Write ADDR=0x0FFF, DATA write 0xBEEF, sel=2'b11 -> bram write at 0xFFF. With WRAP=0: adr stays 0xFFF and OVF=1; writing STATUS=0x0004 clears OVF.
4. CTRL=0x0003, ADDR=0x0FFE, two DATA reads -> mem[0xFFE] then mem[0xFFF], and adr wraps to 0x000 with OVF=0.
5. ADDR write issued while a prefetch is stalled (bram ack held 5 cycles) -> stale data discarded, a second bram read at the new address follows, and the DATA read returns mem[new].
6. Assert wb_rst_ni low while a bram WRITE is pending -> lbram_wb_cyc_o and lbram_wb_stb_o drop the same cycle, and after release adr=0 with PREFETCH of 0 restarted.
